bht_trace_runner: RTL and testbench
===================================

// Module: bht_trace_runner
// PURPOSE
//   Sequencer that replays a branch trace (PC, taken) from a trace memory into the BHT, one record at a time.
//   Per record: fetch the record, sample the BHT prediction for that PC, score it against the actual outcome, then strobe the BHT update.
//   Keeps total and correct prediction counts in hardware, so accuracy runs need no bench-side scoring.
//   Sits between the trace memory and the BHT; the top level or bench drives start/done.
// PARAMETERS
//   PC_W    9   PC bits presented to the BHT (low bits of the trace PC)
//   ADDR_W  10  trace memory address width; max records = 2**ADDR_W
//   CNT_W   32  width of the total/correct counters
// PORTS
//   clk            in   1         clock, all state on rising edge
//   reset          in   1         synchronous, active-high
//   start          in   1         start request; sampled only in IDLE/DONE
//   num_records    in   ADDR_W+1  record count; latched when start is accepted
//   mem_req        out  1         trace memory read request
//   mem_addr       out  ADDR_W    trace record index
//   mem_ack        in   1         read data valid; mem_pc/mem_taken valid this cycle
//   mem_pc         in   PC_W      record PC
//   mem_taken      in   1         record outcome (1 = taken)
//   bht_pc         out  PC_W      PC to BHT (lookup and update)
//   bht_taken      out  1         actual outcome to BHT
//   bht_en         out  1         BHT update strobe; BHT commits only on cycles where this is high
//   bht_prediction in   1         BHT prediction for bht_pc (combinational)
//   busy           out  1         run in progress
//   done           out  1         run complete; held high until next accepted start or reset
//   total_cnt      out  CNT_W     records scored in this run
//   correct_cnt    out  CNT_W     records where prediction == taken
// BEHAVIOUR
//   Reset: state IDLE; mem_req=0, mem_addr=0, bht_en=0, bht_pc=0, bht_taken=0, busy=0, done=0; total_cnt and correct_cnt = 0.
//   Reset mid-run: abort immediately, same values; an outstanding memory read is dropped.
//   States:
//     IDLE: start & num_records==0 -> DONE, counters cleared. start & num_records!=0 -> FETCH; counters cleared, idx=0, count latched.
//     FETCH: mem_req=1, mem_addr=idx; hold until mem_ack.
//       On mem_ack: latch mem_pc/mem_taken into bht_pc/bht_taken -> APPLY. mem_req drops the next cycle.
//     APPLY (exactly 1 cycle): bht_pc/bht_taken stable, bht_en=1.
//       bht_prediction is sampled in this cycle, before the BHT update edge: total_cnt+=1; correct_cnt+=1 if bht_prediction==bht_taken.
//       If idx==latched_count-1 -> DONE, else idx+=1 -> FETCH.
//     DONE: done=1, busy=0, counters frozen. start -> same rules as IDLE (counters cleared on accept).
//   busy=1 in FETCH and APPLY only. start while busy is ignored. mem_ack outside FETCH is ignored.
//   bht_en is high only in APPLY. bht_pc/bht_taken hold their last value at all other times.
//   Latency: min 2 cycles per record (ack in first FETCH cycle); each extra memory wait cycle adds 1.
//   Counters saturate at 2**CNT_W-1 and never wrap.
//   num_records > 2**ADDR_W is clamped to 2**ADDR_W. idx never wraps.
// TESTING
//   1. Reset 2 cycles -> all outputs 0, state IDLE; start with num_records=0 -> done=1 next cycle, total_cnt=0, no mem_req.
//   2. 4 records, mem_ack same cycle, stub BHT predicts always-taken, outcomes 1,1,0,1
//      -> exactly 4 bht_en pulses 2 cycles apart at idx 0..3; total_cnt=4, correct_cnt=3; done=1 after 8 cycles.
//   3. mem_ack delayed 3 cycles per record -> mem_addr and mem_req stable while waiting; 1 bht_en per record; counts unchanged vs test 2.
//   4. start pulsed in FETCH/APPLY, plus spurious mem_ack in APPLY/DONE -> no effect on idx, counts or state.
//   5. Reset mid-run after record 2 -> IDLE, counters 0; restart with 3 records -> total_cnt=3, indices 0,1,2 reissued.
//   6. CNT_W=2, 5 records, all correct -> total_cnt=3, correct_cnt=3 (saturated); restart from DONE clears both to 0.

Source files
------------

// File: rtl/bht_trace_runner_if.sv
// Trace-memory read channel and BHT lookup/update channel of the trace runner.
interface bht_trace_runner_if #(
  parameter int unsigned PC_W   = 9,
  parameter int unsigned ADDR_W = 10
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [PC_W-1:0]   mem_pc;
  logic              mem_taken;
  logic [PC_W-1:0]   bht_pc;
  logic              bht_taken;
  logic              bht_en;
  logic              bht_prediction;

  // Runner side: issues reads, drives the BHT.
  modport master (
    output mem_req, mem_addr, bht_pc, bht_taken, bht_en,
    input  mem_ack, mem_pc, mem_taken, bht_prediction
  );

  // Memory / BHT side.
  modport slave (
    input  mem_req, mem_addr, bht_pc, bht_taken, bht_en,
    output mem_ack, mem_pc, mem_taken, bht_prediction
  );
endinterface

// File: rtl/bht_trace_runner.sv
// Replays a (PC, taken) branch trace from memory into a BHT, one record per FETCH/APPLY pair,
// and scores the BHT prediction against the recorded outcome with saturating counters.
module bht_trace_runner #(
  parameter int unsigned PC_W   = 9,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W:0]     num_records,
  bht_trace_runner_if.master  bus,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    total_cnt,
  output logic [CNT_W-1:0]    correct_cnt
);

  typedef enum logic [1:0] {StIdle, StFetch, StApply, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              taken_q, taken_d;
  logic [CNT_W-1:0]  total_q, total_d;
  logic [CNT_W-1:0]  correct_q, correct_d;
  logic [ADDR_W-1:0] last_start;

  // Index of the final record; any count with the top bit set is clamped to the full memory.
  always_comb begin
    last_start = '1;
    if (!num_records[ADDR_W]) begin
      last_start = num_records[ADDR_W-1:0] - ADDR_W'(1);
    end
  end

  // Next-state logic: run sequencing, record latch and scoring.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    last_d    = last_q;
    pc_d      = pc_q;
    taken_d   = taken_q;
    total_d   = total_q;
    correct_d = correct_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          total_d   = '0;
          correct_d = '0;
          idx_d     = '0;
          last_d    = last_start;
          state_d   = (num_records == '0) ? StDone : StFetch;
        end
      end
      StFetch: begin
        if (bus.mem_ack) begin
          pc_d    = bus.mem_pc;
          taken_d = bus.mem_taken;
          state_d = StApply;
        end
      end
      StApply: begin
        // Prediction is sampled here, before the edge on which the BHT commits the update.
        if (total_q != '1) begin
          total_d = total_q + CNT_W'(1);
        end
        if ((bus.bht_prediction == taken_q) && (correct_q != '1)) begin
          correct_d = correct_q + CNT_W'(1);
        end
        if (idx_q == last_q) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous reset; a reset mid-run drops any outstanding read.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      last_q    <= '0;
      pc_q      <= '0;
      taken_q   <= 1'b0;
      total_q   <= '0;
      correct_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      pc_q      <= pc_d;
      taken_q   <= taken_d;
      total_q   <= total_d;
      correct_q <= correct_d;
    end
  end

  assign bus.mem_req   = (state_q == StFetch);
  assign bus.mem_addr  = idx_q;
  assign bus.bht_en    = (state_q == StApply);
  assign bus.bht_pc    = pc_q;
  assign bus.bht_taken = taken_q;
  assign busy          = (state_q == StFetch) || (state_q == StApply);
  assign done          = (state_q == StDone);
  assign total_cnt     = total_q;
  assign correct_cnt   = correct_q;

endmodule

// File: tb/tb_bht_trace_runner.sv
// Bench for bht_trace_runner: randomized traces, a trace-memory responder with configurable wait
// states, a 2-bit-counter BHT stub, and a trace-level reference model of the expected scores.
module tb_bht_trace_runner;
  localparam int PC_W   = 9;
  localparam int ADDR_W = 10;
  localparam int NMAX   = 1 << ADDR_W;
  localparam int NPC    = 1 << PC_W;

  logic clk = 1'b0;
  logic reset, start;
  logic [ADDR_W:0] num_records;
  logic busy, done, busy2, done2;
  logic [31:0] total_cnt, correct_cnt;
  logic [1:0]  total2, correct2;

  bht_trace_runner_if #(.PC_W(PC_W), .ADDR_W(ADDR_W)) bus ();
  bht_trace_runner_if #(.PC_W(PC_W), .ADDR_W(ADDR_W)) bus2 ();

  bht_trace_runner #(.PC_W(PC_W), .ADDR_W(ADDR_W), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .num_records(num_records), .bus(bus),
    .busy(busy), .done(done), .total_cnt(total_cnt), .correct_cnt(correct_cnt)
  );

  // Narrow-counter copy runs in lockstep on the same memory/BHT responses.
  bht_trace_runner #(.PC_W(PC_W), .ADDR_W(ADDR_W), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .start(start), .num_records(num_records), .bus(bus2),
    .busy(busy2), .done(done2), .total_cnt(total2), .correct_cnt(correct2)
  );

  assign bus2.mem_ack        = bus.mem_ack;
  assign bus2.mem_pc         = bus.mem_pc;
  assign bus2.mem_taken      = bus.mem_taken;
  assign bus2.bht_prediction = bus.bht_prediction;

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  logic [PC_W-1:0] tr_pc [NMAX];
  bit              tr_taken [NMAX];

  // BHT stub: always-taken or a table of 2-bit counters, committing on bht_en edges.
  bit       pred_always = 1'b1;
  bit       ctr_clear = 1'b0;
  bit [1:0] ctr [NPC];
  assign bus.bht_prediction = pred_always ? 1'b1 : ctr[bus.bht_pc][1];

  always @(posedge clk) begin
    if (ctr_clear) begin
      for (int i = 0; i < NPC; i++) ctr[i] <= 2'd1;
    end else if (bus.bht_en === 1'b1) begin
      if (bus.bht_taken && ctr[bus.bht_pc] != 2'd3) ctr[bus.bht_pc] <= ctr[bus.bht_pc] + 2'd1;
      else if (!bus.bht_taken && ctr[bus.bht_pc] != 2'd0) ctr[bus.bht_pc] <= ctr[bus.bht_pc] - 2'd1;
    end
  end

  // Memory responder and observers.
  int  cyc = 0;
  int  wait_cnt = 0;
  int  ack_delay = 0;
  int  fixed_delay = 0;
  bit  rand_delay = 1'b0;
  bit  spurious = 1'b0;
  int  addr_q [$];
  logic [PC_W-1:0] en_pc_q [$];
  bit  en_t_q [$];
  int  en_cyc_q [$];
  int  req_cycles = 0;
  int  unstable = 0;
  logic prev_req = 1'b0;
  logic prev_ack = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.bht_en === 1'b1) begin
      en_pc_q.push_back(bus.bht_pc);
      en_t_q.push_back(bus.bht_taken);
      en_cyc_q.push_back(cyc);
    end
    if (bus.mem_req === 1'b1) req_cycles++;
    if (bus.mem_req === 1'b1 && prev_req && !prev_ack && bus.mem_addr !== prev_addr) unstable++;
    prev_req  = (bus.mem_req === 1'b1);
    prev_addr = bus.mem_addr;
    if (bus.mem_req === 1'b1) begin
      if (wait_cnt >= ack_delay) begin
        bus.mem_ack   = 1'b1;
        bus.mem_pc    = tr_pc[bus.mem_addr];
        bus.mem_taken = tr_taken[bus.mem_addr];
        addr_q.push_back(int'(bus.mem_addr));
        wait_cnt  = 0;
        ack_delay = rand_delay ? int'($urandom_range(0, 3)) : fixed_delay;
      end else begin
        bus.mem_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      bus.mem_ack   = spurious;
      bus.mem_pc    = PC_W'($urandom);
      bus.mem_taken = 1'($urandom);
      wait_cnt      = 0;
    end
    prev_ack = bus.mem_ack;
  end

  // Reference model: replays the trace at record level.
  int exp_total, exp_correct;
  logic [PC_W-1:0] exp_pc_q [$];
  bit exp_t_q [$];

  task automatic model(input int n);
    int mctr [NPC];
    int ne;
    bit pred;
    ne = (n > NMAX) ? NMAX : n;
    exp_pc_q.delete();
    exp_t_q.delete();
    exp_total = ne;
    exp_correct = 0;
    for (int i = 0; i < NPC; i++) mctr[i] = 1;
    for (int i = 0; i < ne; i++) begin
      pred = pred_always ? 1'b1 : (mctr[tr_pc[i]] >= 2);
      if (pred == tr_taken[i]) exp_correct++;
      if (tr_taken[i]) mctr[tr_pc[i]] = (mctr[tr_pc[i]] < 3) ? mctr[tr_pc[i]] + 1 : 3;
      else             mctr[tr_pc[i]] = (mctr[tr_pc[i]] > 0) ? mctr[tr_pc[i]] - 1 : 0;
      exp_pc_q.push_back(tr_pc[i]);
      exp_t_q.push_back(tr_taken[i]);
    end
  endtask

  task automatic fill_trace();
    for (int i = 0; i < NMAX; i++) begin
      tr_pc[i]    = PC_W'($urandom);
      tr_taken[i] = 1'($urandom);
    end
  endtask

  // Clear observers and BHT table, then present a start for one cycle.
  task automatic start_run(input int n);
    @(negedge clk);
    addr_q.delete();
    en_pc_q.delete();
    en_t_q.delete();
    en_cyc_q.delete();
    req_cycles = 0;
    unstable   = 0;
    ack_delay  = rand_delay ? int'($urandom_range(0, 3)) : fixed_delay;
    ctr_clear  = 1'b1;
    @(negedge clk);
    ctr_clear   = 1'b0;
    num_records = (ADDR_W+1)'(n);
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < 20000) begin
      @(negedge clk);
      cycles++;
    end
    n_cmp++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_done: done=%b after %0d cycles, required 1", done, cycles);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    num_records = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({bus.mem_req, bus.mem_addr, bus.bht_en, bus.bht_pc, bus.bht_taken, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: req=%b addr=%0d en=%b pc=%0d tk=%b busy=%b done=%b, required all 0",
               bus.mem_req, bus.mem_addr, bus.bht_en, bus.bht_pc, bus.bht_taken, busy, done);
    end
    n_cmp++;
    if (total_cnt !== 32'd0 || correct_cnt !== 32'd0 || total2 !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_counts: total=%0d correct=%0d total2=%0d, required 0",
               total_cnt, correct_cnt, total2);
    end
    reset = 1'b0;
    start_run(0);
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0 || total_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL zero_records: done=%b busy=%b total=%0d, required 1/0/0", done, busy, total_cnt);
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (req_cycles !== 0) begin
      n_fail++;
      $display("FAIL zero_records_req: %0d mem_req cycles, required 0", req_cycles);
    end
  endtask

  task automatic test_basic();
    int cycles;
    int bad;
    pred_always = 1'b1;
    fill_trace();
    tr_taken[0] = 1'b1; tr_taken[1] = 1'b1; tr_taken[2] = 1'b0; tr_taken[3] = 1'b1;
    fixed_delay = 0;
    rand_delay  = 1'b0;
    start_run(4);
    wait_done(cycles);
    n_cmp++;
    if (cycles !== 8) begin
      n_fail++;
      $display("FAIL basic_latency: done after %0d cycles, required 8", cycles);
    end
    n_cmp++;
    if (total_cnt !== 32'd4 || correct_cnt !== 32'd3) begin
      n_fail++;
      $display("FAIL basic_counts: total=%0d correct=%0d, required 4/3", total_cnt, correct_cnt);
    end
    bad = (en_pc_q.size() == 4 && addr_q.size() == 4) ? -1 : 99;
    for (int i = 0; i < 4 && bad < 0; i++) begin
      if (addr_q[i] != i || en_pc_q[i] !== tr_pc[i] || en_t_q[i] != tr_taken[i]) bad = i;
      if (i > 0 && en_cyc_q[i] - en_cyc_q[i-1] != 2) bad = i;
    end
    n_cmp++;
    if (bad != -1) begin
      n_fail++;
      $display("FAIL basic_pulses: %0d pulses, first bad record %0d, required 4 pulses 2 apart",
               en_pc_q.size(), bad);
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus.bht_pc !== tr_pc[3] || bus.bht_taken !== 1'b1 || bus.bht_en !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_hold: pc=%0d tk=%b en=%b, required %0d/1/0",
               bus.bht_pc, bus.bht_taken, bus.bht_en, tr_pc[3]);
    end
  endtask

  task automatic test_wait_states();
    int cycles;
    int bad;
    fixed_delay = 3;
    start_run(4);
    wait_done(cycles);
    n_cmp++;
    if (cycles !== 20 || req_cycles !== 16) begin
      n_fail++;
      $display("FAIL wait_latency: %0d cycles, %0d req cycles, required 20/16", cycles, req_cycles);
    end
    n_cmp++;
    if (total_cnt !== 32'd4 || correct_cnt !== 32'd3 || en_pc_q.size() != 4) begin
      n_fail++;
      $display("FAIL wait_counts: total=%0d correct=%0d pulses=%0d, required 4/3/4",
               total_cnt, correct_cnt, en_pc_q.size());
    end
    bad = (addr_q.size() == 4) ? -1 : 99;
    for (int i = 0; i < 4 && bad < 0; i++) if (addr_q[i] != i) bad = i;
    n_cmp++;
    if (unstable != 0 || bad != -1) begin
      n_fail++;
      $display("FAIL wait_addr: %0d unstable cycles, first bad index %0d, required 0/-1", unstable, bad);
    end
    fixed_delay = 0;
  endtask

  task automatic test_ignore();
    int cycles;
    int k;
    fill_trace();
    pred_always = 1'b1;
    fixed_delay = 1;
    model(5);
    start_run(5);
    k = 0;
    while (busy === 1'b1 && k < 200) begin
      start       = 1'($urandom);
      num_records = (ADDR_W+1)'($urandom);
      spurious    = 1'b1;
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    wait_done(cycles);
    repeat (3) @(negedge clk);
    spurious = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_state: done=%b busy=%b, required 1/0", done, busy);
    end
    n_cmp++;
    if (total_cnt !== 32'(exp_total) || correct_cnt !== 32'(exp_correct)) begin
      n_fail++;
      $display("FAIL ignore_counts: total=%0d correct=%0d, required %0d/%0d",
               total_cnt, correct_cnt, exp_total, exp_correct);
    end
    n_cmp++;
    if (en_pc_q.size() != 5 || addr_q.size() != 5 || addr_q[4] != 4) begin
      n_fail++;
      $display("FAIL ignore_records: pulses=%0d reads=%0d, required 5/5", en_pc_q.size(), addr_q.size());
    end
    fixed_delay = 0;
  endtask

  task automatic test_reset_mid_run();
    int cycles;
    int k;
    int bad;
    fill_trace();
    pred_always = 1'b0;
    start_run(6);
    k = 0;
    while (en_pc_q.size() < 2 && k < 100) begin
      @(negedge clk);
      k++;
    end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus.mem_req, bus.mem_addr, bus.bht_en, bus.bht_pc, bus.bht_taken, busy, done} !== '0 ||
        total_cnt !== 32'd0 || correct_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: req=%b addr=%0d busy=%b done=%b total=%0d, required all 0",
               bus.mem_req, bus.mem_addr, busy, done, total_cnt);
    end
    reset = 1'b0;
    model(3);
    start_run(3);
    wait_done(cycles);
    n_cmp++;
    if (total_cnt !== 32'd3 || correct_cnt !== 32'(exp_correct)) begin
      n_fail++;
      $display("FAIL midreset_counts: total=%0d correct=%0d, required 3/%0d",
               total_cnt, correct_cnt, exp_correct);
    end
    bad = (addr_q.size() == 3) ? -1 : 99;
    for (int i = 0; i < 3 && bad < 0; i++) if (addr_q[i] != i) bad = i;
    n_cmp++;
    if (bad != -1) begin
      n_fail++;
      $display("FAIL midreset_indices: %0d reads, first bad %0d, required 0,1,2", addr_q.size(), bad);
    end
  endtask

  task automatic test_saturation();
    int cycles;
    pred_always = 1'b1;
    for (int i = 0; i < NMAX; i++) tr_taken[i] = 1'b1;
    start_run(5);
    wait_done(cycles);
    n_cmp++;
    if (total2 !== 2'd3 || correct2 !== 2'd3 || total_cnt !== 32'd5) begin
      n_fail++;
      $display("FAIL sat_counts: total2=%0d correct2=%0d total=%0d, required 3/3/5",
               total2, correct2, total_cnt);
    end
    start_run(2);
    n_cmp++;
    if (total2 !== 2'd0 || correct2 !== 2'd0 || total_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL sat_clear: total2=%0d correct2=%0d total=%0d, required 0/0/0",
               total2, correct2, total_cnt);
    end
    wait_done(cycles);
    n_cmp++;
    if (total2 !== 2'd2 || correct2 !== 2'd2) begin
      n_fail++;
      $display("FAIL sat_rerun: total2=%0d correct2=%0d, required 2/2", total2, correct2);
    end
  endtask

  task automatic test_random();
    int cycles;
    int n;
    int bad;
    int sat;
    pred_always = 1'b0;
    for (int it = 0; it < 10; it++) begin
      fill_trace();
      n = (it == 8) ? 1500 : (it == 9) ? NMAX : int'($urandom_range(1, 40));
      rand_delay = (it < 8);
      model(n);
      start_run(n);
      wait_done(cycles);
      n_cmp++;
      if (total_cnt !== 32'(exp_total) || correct_cnt !== 32'(exp_correct)) begin
        n_fail++;
        $display("FAIL rand_counts[%0d]: n=%0d total=%0d correct=%0d, required %0d/%0d",
                 it, n, total_cnt, correct_cnt, exp_total, exp_correct);
      end
      bad = (addr_q.size() == exp_total && en_pc_q.size() == exp_total) ? -1 : 99999;
      for (int i = 0; i < exp_total && bad < 0; i++) begin
        if (addr_q[i] != i || en_pc_q[i] !== exp_pc_q[i] || en_t_q[i] != exp_t_q[i]) bad = i;
      end
      n_cmp++;
      if (bad != -1) begin
        n_fail++;
        $display("FAIL rand_sequence[%0d]: reads=%0d pulses=%0d first bad %0d, required %0d records",
                 it, addr_q.size(), en_pc_q.size(), bad, exp_total);
      end
      sat = (exp_total > 3) ? 3 : exp_total;
      n_cmp++;
      if (total2 !== 2'(sat) || done2 !== 1'b1 || unstable != 0) begin
        n_fail++;
        $display("FAIL rand_narrow[%0d]: total2=%0d done2=%b unstable=%0d, required %0d/1/0",
                 it, total2, done2, unstable, sat);
      end
    end
    rand_delay = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    num_records = '0;
    test_reset();
    test_basic();
    test_wait_states();
    test_ignore();
    test_reset_mid_run();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
